// File: rtl/wb_stage_ex.sv
// Writeback stage: retires one MEM bundle per handshake and drives the regfile, the CSR port and the trace port.
// It also commits exceptions and ertn, and can wait a configurable number of cycles for CSR read data.
module wb_stage_ex #(
   parameter int DATA_W     = 32,
   parameter int RF_AW      = 5,
   parameter int CSR_NW     = 14,
   parameter int ECODE_W    = 6,
   parameter int CSR_RD_LAT = 0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               ms2ws_valid,
   output logic               ws_allowin,
   input  logic [DATA_W-1:0]  ms_pc,
   input  logic               ms_rf_we,
   input  logic [RF_AW-1:0]   ms_rf_waddr,
   input  logic [DATA_W-1:0]  ms_rf_wdata,
   input  logic               ms_csr_re,
   input  logic               ms_csr_we,
   input  logic [CSR_NW-1:0]  ms_csr_num,
   input  logic [DATA_W-1:0]  ms_csr_wmask,
   input  logic [DATA_W-1:0]  ms_csr_wdata,
   input  logic               ms_ex,
   input  logic [ECODE_W-1:0] ms_ecode,
   input  logic               ms_ertn,
   input  logic [DATA_W-1:0]  csr_rvalue,
   output logic               csr_re,
   output logic               csr_we,
   output logic [CSR_NW-1:0]  csr_num,
   output logic [DATA_W-1:0]  csr_wmask,
   output logic [DATA_W-1:0]  csr_wdata,
   output logic               wb_ex,
   output logic [ECODE_W-1:0] wb_ecode,
   output logic [DATA_W-1:0]  wb_pc,
   output logic               ertn_flush,
   output logic               ws_flush,
   output logic               ws_rf_we,
   output logic [RF_AW-1:0]   ws_rf_waddr,
   output logic [DATA_W-1:0]  ws_rf_wdata,
   output logic [DATA_W-1:0]  debug_wb_pc,
   output logic [3:0]         debug_wb_rf_we,
   output logic [RF_AW-1:0]   debug_wb_rf_wnum,
   output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

   localparam int CNT_W = (CSR_RD_LAT > 0) ? $clog2(CSR_RD_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CSR_RD_LAT);

   logic               ws_valid;
   logic               ws_ready_go;
   logic               commit;
   logic               accept;
   logic               normal;
   logic [CNT_W-1:0]   cnt;

   logic [DATA_W-1:0]  pc_lat;
   logic               rf_we_lat;
   logic [RF_AW-1:0]   waddr_lat;
   logic [DATA_W-1:0]  wdata_lat;
   logic               csr_re_lat;
   logic               csr_we_lat;
   logic [CSR_NW-1:0]  csr_num_lat;
   logic [DATA_W-1:0]  csr_wmask_lat;
   logic [DATA_W-1:0]  csr_wdata_lat;
   logic               ex_lat;
   logic [ECODE_W-1:0] ecode_lat;
   logic               ertn_lat;

   // An excepting instruction never needs its CSR read data, so it does not wait.
   assign ws_ready_go = ~csr_re_lat | (cnt == CNT_MAX) | ex_lat;
   assign ws_allowin  = ~ws_valid | ws_ready_go;
   assign commit      = ws_valid & ws_ready_go;
   assign accept      = ms2ws_valid & ws_allowin & ~ws_flush;

   always_ff @(posedge clk) begin
      if (!resetn)
         ws_valid <= 1'b0;
      else if (ws_flush)
         ws_valid <= 1'b0;
      else if (ws_allowin)
         ws_valid <= ms2ws_valid;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt <= '0;
      else if (accept)
         cnt <= '0;
      else if (ws_valid & csr_re_lat & (cnt < CNT_MAX))
         cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_lat        <= '0;
         rf_we_lat     <= 1'b0;
         waddr_lat     <= '0;
         wdata_lat     <= '0;
         csr_re_lat    <= 1'b0;
         csr_we_lat    <= 1'b0;
         csr_num_lat   <= '0;
         csr_wmask_lat <= '0;
         csr_wdata_lat <= '0;
         ex_lat        <= 1'b0;
         ecode_lat     <= '0;
         ertn_lat      <= 1'b0;
      end else if (accept) begin
         pc_lat        <= ms_pc;
         rf_we_lat     <= ms_rf_we;
         waddr_lat     <= ms_rf_waddr;
         wdata_lat     <= ms_rf_wdata;
         csr_re_lat    <= ms_csr_re;
         csr_we_lat    <= ms_csr_we;
         csr_num_lat   <= ms_csr_num;
         csr_wmask_lat <= ms_csr_wmask;
         csr_wdata_lat <= ms_csr_wdata;
         ex_lat        <= ms_ex;
         ecode_lat     <= ms_ecode;
         ertn_lat      <= ms_ertn;
      end
   end

   // Exception beats ertn beats a normal retire.
   assign wb_ex      = commit & ex_lat;
   assign ertn_flush = commit & ertn_lat & ~ex_lat;
   assign ws_flush   = wb_ex | ertn_flush;
   assign normal     = commit & ~ex_lat & ~ertn_lat;

   assign wb_ecode = ecode_lat;
   assign wb_pc    = pc_lat;

   assign csr_re    = ws_valid & csr_re_lat;
   assign csr_we    = normal & csr_we_lat;
   assign csr_num   = csr_num_lat;
   assign csr_wmask = csr_wmask_lat;
   assign csr_wdata = csr_wdata_lat;

   assign ws_rf_we    = normal & rf_we_lat;
   assign ws_rf_waddr = waddr_lat;
   assign ws_rf_wdata = csr_re_lat ? csr_rvalue : wdata_lat;

   assign debug_wb_pc       = pc_lat;
   assign debug_wb_rf_we    = {4{ws_rf_we}};
   assign debug_wb_rf_wnum  = ws_rf_waddr;
   assign debug_wb_rf_wdata = ws_rf_wdata;

endmodule
